// File: rtl/conv2_pkg.sv
// Shared types and constants for the conv2 kernel-fetch controller.
package conv2_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int PAIR_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } kfetch_state_e;

endpackage

// File: rtl/conv2_kfetch_ctrl_if.sv
// Kernel-fetch bus: host control, dual-port ROM and the weight-pair stream.
// Optional macro CONV2_KFETCH_SUM_EN adds the w_sum running total.
interface conv2_kfetch_ctrl_if #(
  parameter int ADDR_W = conv2_pkg::ADDR_W_DEF,
  parameter int DATA_W = conv2_pkg::DATA_W_DEF
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_pairs;
  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_last;
  logic              busy;
  logic              done;

`ifdef CONV2_KFETCH_SUM_EN
  logic signed [DATA_W+ADDR_W:0] w_sum;

  modport slave (
    input  start, base_addr, num_pairs, q_a, q_b, w_ready,
    output address_a, address_b, w_valid, w_a, w_b, w_last, busy, done, w_sum
  );
  modport master (
    output start, base_addr, num_pairs, q_a, q_b, w_ready,
    input  address_a, address_b, w_valid, w_a, w_b, w_last, busy, done, w_sum
  );
`else
  modport slave (
    input  start, base_addr, num_pairs, q_a, q_b, w_ready,
    output address_a, address_b, w_valid, w_a, w_b, w_last, busy, done
  );
  modport master (
    output start, base_addr, num_pairs, q_a, q_b, w_ready,
    input  address_a, address_b, w_valid, w_a, w_b, w_last, busy, done
  );
`endif

endinterface

// File: rtl/conv2_pair_skid.sv
// Two-entry weight-pair FIFO; head is registered and held stable until popped.
// No write-side ready: the controller only issues a read when a slot is guaranteed.
module conv2_pair_skid
  import conv2_pkg::*;
#(
  parameter int W = 2 * DATA_W_DEF + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem [PAIR_BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign out_vld = (count != 2'd0);
  assign out_dat = mem[rd_ptr];
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAIR_BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_vld) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(in_vld) - 2'(pop);
    end
  end

endmodule

// File: rtl/conv2_kfetch_ctrl.sv
// Kernel weight fetch from a dual-port ROM into a 2-pair stream; first pair 2 cycles after start.
// Optional macro CONV2_KFETCH_SUM_EN adds w_sum, the signed total of the popped weights.
module conv2_kfetch_ctrl
  import conv2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  conv2_kfetch_ctrl_if.slave bus
);

  localparam int PAIR_W = 2 * DATA_W + 1;

  kfetch_state_e     state, state_nxt;
  logic [ADDR_W-1:0] base_r, npairs_r, idx_r;
  logic [ADDR_W-1:0] addr_a_r, addr_b_r, iss_addr;
  logic              issue, issue_last, latch, done_nxt, done_r;
  logic              inflight, inflight_last;
  logic [1:0]        occ;
  logic              fifo_vld, pop, room;
  logic [PAIR_W-1:0] fifo_dat;

  assign pop  = fifo_vld & bus.w_ready;
  // A read is only issued if its data is certain to find a free slot next cycle.
  assign room = ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    latch      = 1'b0;
    done_nxt   = 1'b0;
    iss_addr   = base_r + {idx_r[ADDR_W-2:0], 1'b0};
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch = 1'b1;
          if (bus.num_pairs == '0) begin
            done_nxt = 1'b1;
          end else begin
            // Pair 0 is read straight from the start cycle so w_valid lands 2 cycles later.
            issue      = 1'b1;
            iss_addr   = bus.base_addr;
            issue_last = (bus.num_pairs == ADDR_W'(1));
            state_nxt  = issue_last ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (room) begin
          issue      = 1'b1;
          issue_last = (idx_r == npairs_r - ADDR_W'(1));
          if (issue_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_dat[PAIR_W-1]) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_r        <= '0;
      npairs_r      <= '0;
      idx_r         <= '0;
      addr_a_r      <= '0;
      addr_b_r      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r        <= done_nxt;
      inflight      <= issue;
      inflight_last <= issue_last;
      if (latch) begin
        base_r   <= bus.base_addr;
        npairs_r <= bus.num_pairs;
      end
      if (issue) begin
        addr_a_r <= iss_addr;
        addr_b_r <= iss_addr + ADDR_W'(1);
        idx_r    <= (state == IDLE) ? ADDR_W'(1) : idx_r + ADDR_W'(1);
      end
    end
  end

  conv2_pair_skid #(.W(PAIR_W)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .in_vld  (inflight),
    .in_dat  ({inflight_last, bus.q_a, bus.q_b}),
    .out_vld (fifo_vld),
    .out_rdy (bus.w_ready),
    .out_dat (fifo_dat),
    .count   (occ)
  );

  // The ROM has no enable, so the address is held between issues.
  assign bus.address_a = issue ? iss_addr : addr_a_r;
  assign bus.address_b = issue ? iss_addr + ADDR_W'(1) : addr_b_r;
  assign bus.w_valid   = fifo_vld;
  assign bus.w_a       = fifo_dat[2*DATA_W-1:DATA_W];
  assign bus.w_b       = fifo_dat[DATA_W-1:0];
  assign bus.w_last    = fifo_vld & fifo_dat[PAIR_W-1];
  assign bus.done      = done_r;
  assign bus.busy      = (state != IDLE) || (bus.start && (bus.num_pairs == '0));

`ifdef CONV2_KFETCH_SUM_EN
  localparam int SUM_W = DATA_W + ADDR_W + 1;
  logic signed [SUM_W-1:0] sum_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  sum_r <= '0;
    else if (latch) sum_r <= '0;
    else if (pop)   sum_r <= sum_r + SUM_W'($signed(bus.w_a)) + SUM_W'($signed(bus.w_b));
  end

  assign bus.w_sum = sum_r;
`endif

endmodule

// File: tb/tb_conv2_kfetch_ctrl.sv
// Self-checking bench for conv2_kfetch_ctrl: directed cases plus randomized fetches vs a pair-list model.
// Build with CONV2_KFETCH_SUM_EN defined to also check the w_sum total.
module tb_conv2_kfetch_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } pair_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  conv2_kfetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  conv2_kfetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] rom [256];
  always @(posedge clock) begin
    bus.q_a <= rom[bus.address_a];
    bus.q_b <= rom[bus.address_b];
  end

  int    n_tests = 0;
  int    n_fail  = 0;
  pair_t exp_q[$];
  logic [AW-1:0] la [64];
  logic [AW-1:0] lb [64];
  bit    lv [64];
  bit    ll [64];
  bit    ld [64];
  bit    lbusy [64];
  int    done_cyc;
  int    beats;
  longint sum_at_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero();
    check("rst_w_valid", bus.w_valid, 0);
    check("rst_w_last", bus.w_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_address_a", bus.address_a, 0);
    check("rst_address_b", bus.address_b, 0);
    check("rst_w_a", bus.w_a, 0);
    check("rst_w_b", bus.w_b, 0);
  endtask

  // One fetch: start in cycle 0, then sample each cycle at the falling edge.
  task automatic run_fetch(input logic [AW-1:0] base, input logic [AW-1:0] n,
                           input int mode, input int abort_beat);
    pair_t         p;
    pair_t         held;
    bit            stalled;
    bit            fin;
    int            k;
    logic [AW-1:0] ad;
    longint        exp_sum;
    stalled = 0;
    fin     = 0;
    k       = 0;
    exp_sum = 0;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      ad     = base + AW'(2 * i);
      p.a    = rom[ad];
      p.b    = rom[ad + 8'd1];
      p.last = (i == int'(n) - 1);
      exp_q.push_back(p);
      exp_sum += longint'($signed(p.a)) + longint'($signed(p.b));
    end
    done_cyc    = -1;
    beats       = 0;
    sum_at_done = 0;
    for (int i = 0; i < 64; i++) begin
      la[i] = '0; lb[i] = '0; lv[i] = 0; ll[i] = 0; ld[i] = 0; lbusy[i] = 0;
    end
    while (!fin) begin
      @(posedge clock);
      #1;
      bus.start     = (k == 0) || (mode == 2 && k == 1 && n != 0);
      bus.base_addr = (k == 0) ? base : AW'($urandom);
      bus.num_pairs = (k == 0) ? n : AW'($urandom);
      case (mode)
        0:       bus.w_ready = 1'b1;
        1:       bus.w_ready = (k % 4 == 0) || (k % 4 == 3);
        default: bus.w_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clock);
      if (k < 64) begin
        la[k] = bus.address_a; lb[k] = bus.address_b; lv[k] = bus.w_valid;
        ll[k] = bus.w_last; ld[k] = bus.done; lbusy[k] = bus.busy;
      end
      if (stalled) begin
        check("stall_valid", bus.w_valid, 1);
        check("stall_data", {bus.w_a, bus.w_b, bus.w_last}, held);
      end
      if (bus.w_valid && bus.w_ready) begin
        check("beat_in_range", (beats < int'(n)), 1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          check("beat_data", {bus.w_a, bus.w_b, bus.w_last}, p);
        end
        beats++;
      end
      stalled = bus.w_valid && !bus.w_ready;
      held    = {bus.w_a, bus.w_b, bus.w_last};
      if (k >= 1 && done_cyc < 0 && !bus.done) check("busy_in_fetch", bus.busy, 1);
      if (bus.done) begin
        check("single_done", done_cyc, -1);
        check("busy_at_done", bus.busy, 0);
        done_cyc = k;
`ifdef CONV2_KFETCH_SUM_EN
        sum_at_done = longint'(bus.w_sum);
        check("w_sum_model", bus.w_sum, exp_sum);
`endif
      end
      if (abort_beat > 0 && beats == abort_beat) begin
        reset_n = 1'b0;
        #1;
        check_outputs_zero();
        fin = 1;
      end
      if (done_cyc >= 0 && k >= done_cyc + 2) fin = 1;
      if (k >= 300) fin = 1;
      k++;
    end
    if (abort_beat == 0) begin
      check("done_seen", (done_cyc >= 0), 1);
      check("beat_count", beats, n);
      check("model_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_pairs = '0;
    bus.w_ready   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_zero();
    reset_n = 1'b1;

    // Base 0x10, four pairs, consumer always ready.
    run_fetch(8'h10, 8'd4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("seq_addr_a", la[k], 8'h10 + 2 * k);
      check("seq_addr_b", lb[k], 8'h11 + 2 * k);
    end
    for (int k = 0; k < 7; k++) check("seq_w_valid", lv[k], (k >= 2 && k <= 5));
    check("seq_last_b4", ll[5], 1);
    check("seq_last_b3", ll[4], 0);
    check("seq_done_cyc", done_cyc, 6);
    check("seq_no_early_done", ld[5], 0);

    // Address wrap-around.
    run_fetch(8'hFE, 8'd2, 0, 0);
    check("wrap_a0", la[0], 8'hFE);
    check("wrap_b0", lb[0], 8'hFF);
    check("wrap_a1", la[1], 8'h00);
    check("wrap_b1", lb[1], 8'h01);

    // Eight pairs with the consumer ready 1,0,0,1 repeating.
    run_fetch(8'h40, 8'd8, 1, 0);

    // Empty fetch.
    run_fetch(8'h33, 8'd0, 0, 0);
    check("empty_done_cyc", done_cyc, 1);
    check("empty_busy_start", lbusy[0], 1);
    for (int k = 0; k < 4; k++) check("empty_no_valid", lv[k], 0);

    // Reset in the middle of a six-pair fetch, then a clean restart.
    run_fetch(8'h80, 8'd6, 0, 3);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outputs_zero();
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_no_done", bus.done, 0);
    check("post_rst_no_valid", bus.w_valid, 0);
    run_fetch(8'h80, 8'd6, 2, 0);

    for (int r = 0; r < 8; r++)
      run_fetch(AW'($urandom), AW'($urandom_range(0, 12)), 2, 0);

`ifdef CONV2_KFETCH_SUM_EN
    rom[8'h20] = 16'd1;
    rom[8'h21] = 16'hFFFE;
    rom[8'h22] = 16'd3;
    rom[8'h23] = 16'd4;
    run_fetch(8'h20, 8'd2, 0, 0);
    check("w_sum_1m234", sum_at_done, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2_kfetch_ctrl.md
CONV2_KFETCH_CTRL -- requirements
Module: conv2_kfetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, ROM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, ROM word width.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a kernel fetch.
REQ-006 SHALL have port base_addr  in  ADDR_W  first ROM word of the kernel.
REQ-007 SHALL have port num_pairs  in  ADDR_W  number of word pairs to fetch; 0 means an empty fetch.
REQ-008 SHALL have port address_a  out  ADDR_W  ROM port A address.
REQ-009 SHALL have port address_b  out  ADDR_W  ROM port B address.
REQ-010 SHALL have port q_a  in  DATA_W  ROM port A data, valid one cycle after its address is presented.
REQ-011 SHALL have port q_b  in  DATA_W  ROM port B data, same timing as q_a.
REQ-012 SHALL have port w_valid  out  1  a weight pair is available.
REQ-013 SHALL have port w_ready  in  1  the consumer accepts the pair.
REQ-014 SHALL have port w_a  out  DATA_W  even weight of the pair.
REQ-015 SHALL have port w_b  out  DATA_W  odd weight of the pair.
REQ-016 SHALL have port w_last  out  1  marks the final pair of the fetch.
REQ-017 SHALL have port busy  out  1  high from the accepted start until done.
REQ-018 SHALL have port done  out  1  one-cycle pulse when the fetch completes.

Function
REQ-019 SHALL use FSM states IDLE, FETCH and DRAIN.
REQ-020 SHALL, in IDLE with start=1, latch base_addr and num_pairs and go to FETCH; start SHALL be ignored in FETCH and DRAIN.
REQ-021 SHALL, if num_pairs=0, skip FETCH: pulse done on the cycle after start, emit no beats, and return to IDLE.
REQ-022 SHALL, for issue index i, drive address_a=base+2i and address_b=base+2i+1, both modulo 2^ADDR_W (wrap-around, no error).
REQ-023 SHALL count one ROM read as issued in a cycle only when occupancy+inflight-pop < 2, where occupancy is the 2-entry output buffer count and pop = w_valid & w_ready.
REQ-024 SHALL write q_a/q_b into the output buffer exactly one cycle after an issued read.
REQ-025 SHALL hold address_a/address_b at the last issued value when no read is issued; the ROM has no enable.
REQ-026 SHALL go from FETCH to DRAIN on the cycle the last read (i = num_pairs-1) issues.
REQ-027 SHALL go from DRAIN to IDLE when the last-flagged pair pops, pulsing done in the same cycle the state changes.
REQ-028 SHALL sustain one pair per cycle while w_ready=1; first w_valid SHALL appear 2 cycles after start.
REQ-029 SHALL present w_a, w_b and w_last stable while w_valid=1 and w_ready=0; no data SHALL be lost or duplicated under any w_ready pattern.
REQ-030 SHALL assert w_last only with the pair from index num_pairs-1.
REQ-031 SHALL drive busy=1 in FETCH and DRAIN, and on the start cycle of an empty fetch until done.

Reset
REQ-032 SHALL, on reset_n=0, immediately return to IDLE, flush the buffer and in-flight flag, and clear w_valid, w_last, busy, done, address_a, address_b, w_a and w_b to 0.
REQ-033 SHALL discard an aborted fetch's in-flight read and produce no done pulse for it.

Configuration
REQ-034 SHALL implement macro CONV2_KFETCH_SUM_EN: when defined, add output port w_sum (DATA_W+ADDR_W+1 bits), the signed sum of all popped weights of the current fetch, cleared on the accepted start and valid when done pulses.
REQ-035 SHALL, without CONV2_KFETCH_SUM_EN, omit the w_sum port and its accumulator, with all other behaviour identical.

Structure
REQ-036 SHALL place the FSM state enum, the buffer depth constant (2) and the default ADDR_W/DATA_W values in shared package conv2_pkg.
REQ-037 SHALL implement the 2-entry output buffer as sub-module conv2_pair_skid, a 2-deep FIFO with valid/ready and a count output.

Verification
REQ-038 Bench SHALL check: base=0x10, pairs=4, w_ready=1 -> addresses (0x10,0x11)..(0x16,0x17), 4 consecutive beats starting 2 cycles after start, w_last on beat 4, done on the cycle after it.
REQ-039 Bench SHALL check: base=0xFE, pairs=2 -> addresses (0xFE,0xFF) then (0x00,0x01).
REQ-040 Bench SHALL check: pairs=8 with w_ready toggling 1,0,0,1 repeating -> 8 ordered pairs matching ROM contents, data stable while stalled, no loss.
REQ-041 Bench SHALL check: pairs=0 -> done on the cycle after start, w_valid never asserted.
REQ-042 Bench SHALL check: reset_n pulled low at beat 3 of a 6-pair fetch -> all outputs 0, a new start then runs cleanly with no stale data.
REQ-043 Bench SHALL check: with CONV2_KFETCH_SUM_EN defined and weights 1,-2,3,4 -> w_sum=6 when done pulses.
